// File: rtl/irq_controller.sv
// irq_controller: machine-level interrupt controller.
// Contains the MSIP bit, a 64-bit mtime/mtimecmp timer and NUM_EXT
// edge-latched external lines. It drives one request plus a cause code to the
// exception logic. Priority is MEI > MSI > MTI.
// Optional build macro: MTIME_PRESCALE_EN. When it is defined, mtime advances
// once every PRESCALE cycles instead of every cycle.
//
// Request handshake: irq_out is a level that stays high from the cycle the
// request is issued until the core answers with a one-cycle irq_ack. It also
// drops if the sources or mie_global go away first. irq_cause is stable while
// irq_out is high. After the ack no new request is issued until a one-cycle
// mret pulse closes the handler.
module irq_controller #(
   parameter int NUM_EXT  = 8,
   parameter int PRESCALE = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_EXT-1:0] ext_irq,
   input  logic               mie_global,
   input  logic               irq_ack,
   input  logic               mret,
   input  logic [4:0]         bus_addr,
   input  logic [31:0]        bus_wdata,
   input  logic               bus_we,
   input  logic               bus_re,
   output logic [31:0]        bus_rdata,
   output logic               irq_out,
   output logic [3:0]         irq_cause,
   output logic               timer_irq_pending,
   output logic [1:0]         fsm_state
);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SVC = 2'd2} state_t;

   localparam logic [3:0] CAUSE_MEI = 4'd11;
   localparam logic [3:0] CAUSE_MSI = 4'd3;
   localparam logic [3:0] CAUSE_MTI = 4'd7;

   state_t             state, state_n;
   logic               irq_out_n;
   logic [3:0]         irq_cause_n;
   logic               msip;
   logic               mtip;
   logic [63:0]        mtime, mtimecmp;
   logic [NUM_EXT-1:0] ext_pending, ext_enable;
   logic [NUM_EXT-1:0] ext_s1, ext_s2, ext_prev, ext_rise;
   logic [NUM_EXT-1:0] claim_mask, clr_mask;
   logic [31:0]        claim_val, rd_mux;
   logic [2:0]         reg_sel;
   logic               wr_msip, wr_cmp_lo, wr_cmp_hi, wr_mt_lo, wr_mt_hi;
   logic               wr_pend, wr_en, claim_rd, tick;
   logic               src_mei, src_msi, src_any;
   logic [3:0]         win_cause;
   logic               addr_unused;

   assign reg_sel     = bus_addr[4:2];
   assign addr_unused = ^bus_addr[1:0];
   assign wr_msip     = bus_we && (reg_sel == 3'd0);
   assign wr_cmp_lo   = bus_we && (reg_sel == 3'd1);
   assign wr_cmp_hi   = bus_we && (reg_sel == 3'd2);
   assign wr_mt_lo    = bus_we && (reg_sel == 3'd3);
   assign wr_mt_hi    = bus_we && (reg_sel == 3'd4);
   assign wr_pend     = bus_we && (reg_sel == 3'd5);
   assign wr_en       = bus_we && (reg_sel == 3'd6);
   assign claim_rd    = bus_re && (reg_sel == 3'd7);

`ifdef MTIME_PRESCALE_EN
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   logic [PW-1:0] pre_cnt;

   // Prescaler: counts 0..PRESCALE-1; an mtime write restarts the period.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                 pre_cnt <= '0;
      else if (wr_mt_lo || wr_mt_hi)           pre_cnt <= '0;
      else if (pre_cnt == PW'(PRESCALE - 1))   pre_cnt <= '0;
      else                                     pre_cnt <= pre_cnt + 1'b1;
   end

   assign tick = (pre_cnt == PW'(PRESCALE - 1));
`else
   logic prescale_unused;
   assign prescale_unused = (PRESCALE != 0);
   assign tick = 1'b1;
`endif

   // Two-flop synchronizer plus a third stage for rising-edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ext_s1   <= '0;
         ext_s2   <= '0;
         ext_prev <= '0;
      end else begin
         ext_s1   <= ext_irq;
         ext_s2   <= ext_s1;
         ext_prev <= ext_s2;
      end
   end

   assign ext_rise = ext_s2 & ~ext_prev;

   // Claim finds the lowest-index pending and enabled line.
   always_comb begin
      claim_val  = 32'd0;
      claim_mask = '0;
      for (int i = NUM_EXT - 1; i >= 0; i--) begin
         if (ext_pending[i] && ext_enable[i]) begin
            claim_val  = 32'(i + 1);
            claim_mask = '0;
            claim_mask[i] = 1'b1;
         end
      end
   end

   assign clr_mask = (wr_pend ? bus_wdata[NUM_EXT-1:0] : '0) |
                     (claim_rd ? claim_mask : '0);

   // Read mux works on current (pre-write) register values.
   always_comb begin
      rd_mux = 32'd0;
      case (reg_sel)
         3'd0: rd_mux = {31'd0, msip};
         3'd1: rd_mux = mtimecmp[31:0];
         3'd2: rd_mux = mtimecmp[63:32];
         3'd3: rd_mux = mtime[31:0];
         3'd4: rd_mux = mtime[63:32];
         3'd5: rd_mux = 32'(ext_pending);
         3'd6: rd_mux = 32'(ext_enable);
         default: rd_mux = claim_val;
      endcase
   end

   // Bus-visible registers; a new edge beats a same-cycle clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         msip        <= 1'b0;
         mtimecmp    <= '1;
         ext_pending <= '0;
         ext_enable  <= '0;
         bus_rdata   <= 32'd0;
      end else begin
         if (wr_msip)   msip <= bus_wdata[0];
         if (wr_cmp_lo) mtimecmp[31:0]  <= bus_wdata;
         if (wr_cmp_hi) mtimecmp[63:32] <= bus_wdata;
         if (wr_en)     ext_enable <= bus_wdata[NUM_EXT-1:0];
         ext_pending <= (ext_pending & ~clr_mask) | ext_rise;
         if (bus_re)    bus_rdata <= rd_mux;
      end
   end

   // mtime: a bus write replaces one half and suppresses that cycle's increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)           mtime <= 64'd0;
      else if (wr_mt_lo) mtime[31:0]  <= bus_wdata;
      else if (wr_mt_hi) mtime[63:32] <= bus_wdata;
      else if (tick)     mtime <= mtime + 64'd1;
   end

   // Registered timer compare.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) mtip <= 1'b0;
      else     mtip <= (mtime >= mtimecmp);
   end

   assign timer_irq_pending = mtip;
   assign src_mei   = |(ext_pending & ext_enable);
   assign src_msi   = msip;
   assign src_any   = src_mei || src_msi || mtip;
   assign win_cause = src_mei ? CAUSE_MEI : (src_msi ? CAUSE_MSI : CAUSE_MTI);

   // Sequencer next state: request, wait for ack, then block until mret.
   always_comb begin
      state_n     = state;
      irq_out_n   = 1'b0;
      irq_cause_n = irq_cause;
      case (state)
         IDLE: begin
            if (mie_global && src_any) begin
               state_n     = REQ;
               irq_out_n   = 1'b1;
               irq_cause_n = win_cause;
            end
         end
         REQ: begin
            if (irq_ack)                      state_n = SVC;
            else if (!mie_global || !src_any) state_n = IDLE;
            else                              irq_out_n = 1'b1;
         end
         SVC: begin
            if (mret) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Sequencer state and registered request outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         irq_out   <= 1'b0;
         irq_cause <= 4'd0;
      end else begin
         state     <= state_n;
         irq_out   <= irq_out_n;
         irq_cause <= irq_cause_n;
      end
   end

   assign fsm_state = state;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: register table, handshake
// sequences, timer latency, edge/clear races and randomized claim/mtime rounds.
module tb_irq_controller;
   localparam int NUM_EXT  = 8;
   localparam int PRESCALE = 16;
   localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_SVC = 2'd2;

   logic               clk, rst;
   logic [NUM_EXT-1:0] ext_irq;
   logic               mie_global, irq_ack, mret;
   logic [4:0]         bus_addr;
   logic [31:0]        bus_wdata;
   logic               bus_we, bus_re;
   logic [31:0]        bus_rdata;
   logic               irq_out;
   logic [3:0]         irq_cause;
   logic               timer_irq_pending;
   logic [1:0]         fsm_state;

   irq_controller #(.NUM_EXT(NUM_EXT), .PRESCALE(PRESCALE)) dut (
      .clk(clk), .rst(rst), .ext_irq(ext_irq), .mie_global(mie_global),
      .irq_ack(irq_ack), .mret(mret), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_we(bus_we), .bus_re(bus_re), .bus_rdata(bus_rdata), .irq_out(irq_out),
      .irq_cause(irq_cause), .timer_irq_pending(timer_irq_pending),
      .fsm_state(fsm_state)
   );

   // Clock and watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [2:0]  r;
      logic        do_write;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t        vecs[$];
   logic [31:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus_write(input logic [2:0] r, input logic [31:0] d);
      bus_addr  = {r, 2'b00};
      bus_wdata = d;
      bus_we    = 1'b1;
      step();
      bus_we    = 1'b0;
   endtask

   task automatic bus_read(input logic [2:0] r, output logic [31:0] d);
      bus_addr = {r, 2'b00};
      bus_re   = 1'b1;
      step();
      bus_re   = 1'b0;
      d        = bus_rdata;
   endtask

   task automatic read_check(input string name, input logic [2:0] r, input logic [31:0] exp);
      logic [31:0] v;
      bus_read(r, v);
      check(name, v, exp);
   endtask

   task automatic pulse_ext(input logic [NUM_EXT-1:0] m);
      ext_irq = ext_irq | m;
      step(3);
      ext_irq = ext_irq & ~m;
      step(3);
   endtask

   task automatic pulse_ack();
      irq_ack = 1'b1;
      step();
      irq_ack = 1'b0;
   endtask

   task automatic pulse_mret();
      mret = 1'b1;
      step();
      mret = 1'b0;
   endtask

   task automatic wait_irq(input int max, output int cyc);
      cyc = 0;
      while (!irq_out && cyc < max) begin
         step();
         cyc++;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(2);
      rst = 1'b0;
   endtask

   initial begin
      logic [31:0]        v, a, b;
      logic [63:0]        mt;
      logic [NUM_EXT-1:0] en, pul;
      int                 cyc, lo_lim, hi_lim;

      rst = 1'b1; ext_irq = '0; mie_global = 1'b0; irq_ack = 1'b0; mret = 1'b0;
      bus_addr = '0; bus_wdata = '0; bus_we = 1'b0; bus_re = 1'b0;
      step(3);
      rst = 1'b0;

      // Reset state of outputs
      check("rst_irq_out", irq_out, 0);
      check("rst_irq_cause", irq_cause, 0);
      check("rst_bus_rdata", bus_rdata, 0);
      check("rst_mtip", timer_irq_pending, 0);
      check("rst_state", fsm_state, S_IDLE);

      // Register table: reset reads, then write/readback pairs
      vecs.push_back('{3'd0, 1'b0, 32'h0, 32'h0});
      vecs.push_back('{3'd1, 1'b0, 32'h0, 32'hFFFF_FFFF});
      vecs.push_back('{3'd2, 1'b0, 32'h0, 32'hFFFF_FFFF});
      vecs.push_back('{3'd4, 1'b0, 32'h0, 32'h0});
      vecs.push_back('{3'd5, 1'b0, 32'h0, 32'h0});
      vecs.push_back('{3'd6, 1'b0, 32'h0, 32'h0});
      vecs.push_back('{3'd7, 1'b0, 32'h0, 32'h0});
      vecs.push_back('{3'd0, 1'b1, 32'hFFFF_FFFF, 32'h1});
      vecs.push_back('{3'd0, 1'b1, 32'h0, 32'h0});
      vecs.push_back('{3'd1, 1'b1, 32'h1234_5678, 32'h1234_5678});
      vecs.push_back('{3'd2, 1'b1, 32'hCAFE_F00D, 32'hCAFE_F00D});
      vecs.push_back('{3'd6, 1'b1, 32'hFFFF_FFFF, 32'hFF});
      vecs.push_back('{3'd6, 1'b1, 32'h0, 32'h0});
      vecs.push_back('{3'd7, 1'b1, 32'hFFFF_FFFF, 32'h0});
      vecs.push_back('{3'd5, 1'b1, 32'hFFFF_FFFF, 32'h0});
      vecs.push_back('{3'd1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
      vecs.push_back('{3'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].do_write) bus_write(vecs[i].r, vecs[i].wdata);
         read_check($sformatf("vec%0d_reg%0d", i, vecs[i].r), vecs[i].r, vecs[i].exp);
      end

      // mtime advances: two reads 21 cycles apart
      bus_read(3'd3, a);
      step(20);
      bus_read(3'd3, b);
`ifdef MTIME_PRESCALE_EN
      check("mtime_advance", 32'((b - a) >= 1 && (b - a) <= 2), 1);
`else
      check("mtime_advance", b - a, 21);
`endif

      // MSIP request, ack, no nesting, mret re-request
      mie_global = 1'b1;
      bus_write(3'd0, 32'h1);
      step();
      check("msi_irq_out", irq_out, 1);
      check("msi_cause", irq_cause, 3);
      pulse_ack();
      check("ack_irq_out", irq_out, 0);
      check("ack_state", fsm_state, S_SVC);
      step(3);
      check("svc_no_nest", irq_out, 0);
      pulse_mret();
      check("mret_state", fsm_state, S_IDLE);
      step();
      check("rereq_irq_out", irq_out, 1);
      check("rereq_cause", irq_cause, 3);
      pulse_mret();
      check("mret_in_req_ignored", fsm_state, S_REQ);

      // mie_global drop before ack withdraws the request
      mie_global = 1'b0;
      step();
      check("mie_drop_irq_out", irq_out, 0);
      check("mie_drop_state", fsm_state, S_IDLE);

      // Ack and withdrawal in the same cycle: ack wins
      mie_global = 1'b1;
      step();
      check("req_again", fsm_state, S_REQ);
      mie_global = 1'b0;
      pulse_ack();
      check("ack_beats_withdraw", fsm_state, S_SVC);
      pulse_mret();
      step();
      check("idle_mie_off", fsm_state, S_IDLE);
      pulse_ack();
      check("ack_in_idle_ignored", fsm_state, S_IDLE);
      bus_write(3'd0, 32'h0);

      // Timer interrupt latency
      mie_global = 1'b1;
      bus_write(3'd3, 32'd0);
      bus_write(3'd4, 32'd0);
      bus_write(3'd2, 32'd0);
      bus_write(3'd1, 32'd100);
`ifdef MTIME_PRESCALE_EN
      lo_lim = 100 * PRESCALE - 5; hi_lim = 100 * PRESCALE + 5;
`else
      lo_lim = 95; hi_lim = 105;
`endif
      wait_irq(4000, cyc);
      check("mti_irq_out", irq_out, 1);
      check("mti_latency_in_range", 32'(cyc >= lo_lim && cyc <= hi_lim), 1);
      check("mti_cause", irq_cause, 7);
      check("mtip_level", timer_irq_pending, 1);
      pulse_ack();
      bus_write(3'd2, 32'hFFFF_FFFF);
      step();
      check("mtip_cleared", timer_irq_pending, 0);
      pulse_mret();

      // External lines, claim order
      bus_write(3'd6, 32'h0C);
      pulse_ext(8'h08);
      pulse_ext(8'h04);
      check("mei_irq_out", irq_out, 1);
      check("mei_cause", irq_cause, 11);
      read_check("claim_first", 3'd7, 3);
      read_check("claim_second", 3'd7, 4);
      read_check("claim_empty", 3'd7, 0);
      read_check("pending_after_claims", 3'd5, 0);
      step();
      check("idle_after_claims", fsm_state, S_IDLE);

      // MEI beats MSI when both become valid together
      mie_global = 1'b0;
      bus_write(3'd6, 32'h01);
      bus_write(3'd0, 32'h1);
      pulse_ext(8'h01);
      mie_global = 1'b1;
      step();
      check("prio_cause_mei", irq_cause, 11);
      pulse_ack();
      read_check("prio_claim", 3'd7, 1);
      pulse_mret();
      step();
      check("prio_next_irq_out", irq_out, 1);
      check("prio_next_cause_msi", irq_cause, 3);
      pulse_ext(8'h01);
      check("cause_held_in_req", irq_cause, 3);
      pulse_ack();
      bus_write(3'd0, 32'h0);
      read_check("cleanup_claim", 3'd7, 1);
      pulse_mret();
      step();
      check("idle_after_cleanup", fsm_state, S_IDLE);

      // Edge arriving with a W1C of the same bit keeps it set
      mie_global = 1'b0;
      bus_write(3'd6, 32'h0);
      pulse_ext(8'h02);
      ext_irq[1] = 1'b1;
      step(2);
      bus_addr = {3'd5, 2'b00}; bus_wdata = 32'h2; bus_we = 1'b1;
      step();
      bus_we = 1'b0;
      read_check("edge_beats_w1c", 3'd5, 32'h2);
      ext_irq[1] = 1'b0;
      step(3);
      bus_write(3'd5, 32'h2);
      read_check("w1c_clears", 3'd5, 32'h0);

      // Edge arriving with a claim of the same bit keeps it set
      bus_write(3'd6, 32'h2);
      pulse_ext(8'h02);
      ext_irq[1] = 1'b1;
      step(2);
      bus_addr = {3'd7, 2'b00}; bus_re = 1'b1;
      step();
      bus_re = 1'b0;
      check("claim_race_value", bus_rdata, 2);
      read_check("edge_beats_claim", 3'd5, 32'h2);
      ext_irq[1] = 1'b0;
      step(3);
      read_check("claim_again", 3'd7, 2);
      read_check("claim_done", 3'd7, 0);
      bus_write(3'd6, 32'h0);

      // Asynchronous reset in the middle of a request
      mie_global = 1'b1;
      bus_write(3'd0, 32'h1);
      step();
      check("pre_rst_req", irq_out, 1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_irq_out", irq_out, 0);
      check("async_rst_state", fsm_state, S_IDLE);
      step();
      rst = 1'b0;
      read_check("post_rst_cmp_lo", 3'd1, 32'hFFFF_FFFF);
      read_check("post_rst_cmp_hi", 3'd2, 32'hFFFF_FFFF);
      read_check("post_rst_msip", 3'd0, 32'h0);
      check("post_rst_irq_out", irq_out, 0);

      // Randomized claim rounds against a queue model
      mie_global = 1'b0;
      do_reset();
      for (int r = 0; r < 20; r++) begin
         en  = NUM_EXT'($urandom);
         pul = NUM_EXT'($urandom);
         bus_write(3'd6, 32'(en));
         pulse_ext(pul);
         for (int i = 0; i < NUM_EXT; i++)
            if (en[i] && pul[i]) exp_q.push_back(32'(i + 1));
         exp_q.push_back(32'd0);
         while (exp_q.size() > 0) begin
            bus_read(3'd7, v);
            check($sformatf("rand_claim_r%0d", r), v, exp_q.pop_front());
         end
         read_check($sformatf("rand_pending_r%0d", r), 3'd5, 32'(pul & ~en));
         bus_write(3'd5, 32'hFFFF_FFFF);
      end

      // Randomized mtime writes, including full wrap and low-half carry
      for (int r = 0; r < 8; r++) begin
         mt = {$urandom, $urandom};
         if (r == 0) mt = 64'hFFFF_FFFF_FFFF_FFFF;
         if (r == 1) mt[31:0] = 32'hFFFF_FFFF;
         bus_write(3'd4, mt[63:32]);
         bus_write(3'd3, mt[31:0]);
         read_check($sformatf("rand_mtime_lo_r%0d", r), 3'd3, mt[31:0]);
`ifndef MTIME_PRESCALE_EN
         mt = mt + 64'd1;
`endif
         read_check($sformatf("rand_mtime_hi_r%0d", r), 3'd4, mt[63:32]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
